// File: rtl/pool_out_fifo.sv
// pool_out_fifo: show-ahead FIFO behind the pooling/ReLU stage; tags the last pixel of each frame.
// Define POOL_OUT_LAST_EN to expose the head entry's last tag on out_last.
module pool_out_fifo #(
   parameter int CONV_BIT    = 12,
   parameter int HALF_WIDTH  = 12,
   parameter int HALF_HEIGHT = 12,
   parameter int DEPTH       = 16,
   parameter int ADDR_BIT    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid_in,
   input  logic [CONV_BIT-1:0] max_value_1,
   input  logic [CONV_BIT-1:0] max_value_2,
   input  logic [CONV_BIT-1:0] max_value_3,
   output logic [CONV_BIT-1:0] out_data_1,
   output logic [CONV_BIT-1:0] out_data_2,
   output logic [CONV_BIT-1:0] out_data_3,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ADDR_BIT:0]   count,
   output logic                overflow,
   output logic                frame_done
`ifdef POOL_OUT_LAST_EN
   ,
   output logic                out_last
`endif
);

   localparam int COL_BIT = (HALF_WIDTH  > 1) ? $clog2(HALF_WIDTH)  : 1;
   localparam int ROW_BIT = (HALF_HEIGHT > 1) ? $clog2(HALF_HEIGHT) : 1;
   localparam logic [ADDR_BIT:0]  FULL_CNT = (ADDR_BIT+1)'(DEPTH);
   localparam logic [COL_BIT-1:0] COL_LAST = COL_BIT'(HALF_WIDTH - 1);
   localparam logic [ROW_BIT-1:0] ROW_LAST = ROW_BIT'(HALF_HEIGHT - 1);

   typedef struct packed {
      logic                last;
      logic [CONV_BIT-1:0] c3;
      logic [CONV_BIT-1:0] c2;
      logic [CONV_BIT-1:0] c1;
   } entry_t;

   entry_t              mem_q [DEPTH];
   entry_t              head;
   logic [ADDR_BIT-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_BIT:0]   count_q, count_d;
   logic [COL_BIT-1:0]  col_q, col_d;
   logic [ROW_BIT-1:0]  row_q, row_d;
   logic                overflow_q, overflow_d;
   logic                frame_done_q, frame_done_d;
   logic                rd_en, wr_en, drop, full, last_pos;

   assign head     = mem_q[rd_ptr_q];
   assign full     = (count_q == FULL_CNT);
   assign rd_en    = out_valid & out_ready;
   // A full FIFO still accepts a sample when the head leaves in the same cycle.
   assign wr_en    = valid_in & (~full | rd_en);
   assign drop     = valid_in & full & ~rd_en;
   assign last_pos = (col_q == COL_LAST) && (row_q == ROW_LAST);

   always_comb begin
      // NOTE: every _d gets its hold value first, so no branch can leave one unassigned and infer a latch.
      count_d      = count_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      col_d        = col_q;
      row_d        = row_q;
      overflow_d   = overflow_q | drop;
      frame_done_d = rd_en & head.last;
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      // Position tracks every upstream sample, dropped or not, to stay frame-aligned.
      if (valid_in) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         col_q        <= '0;
         row_q        <= '0;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         count_q      <= count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         col_q        <= col_d;
         row_q        <= row_d;
         overflow_q   <= overflow_d;
         frame_done_q <= frame_done_d;
      end
   end

   // NOTE: storage is left unreset; emptiness is tracked by count_q, so stale words are never presented as valid.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= {last_pos, max_value_3, max_value_2, max_value_1};
   end

   assign out_valid  = (count_q != '0);
   assign out_data_1 = head.c1;
   assign out_data_2 = head.c2;
   assign out_data_3 = head.c3;
   assign count      = count_q;
   assign overflow   = overflow_q;
   assign frame_done = frame_done_q;
`ifdef POOL_OUT_LAST_EN
   assign out_last   = out_valid & head.last;
`endif

endmodule

// File: tb/tb_pool_out_fifo.sv
// Directed bench for pool_out_fifo: reset, ordering, full/overflow, frame_done and mid-frame reset.
module tb_pool_out_fifo;

   localparam int CB    = 12;
   localparam int HW    = 12;
   localparam int HH    = 12;
   localparam int DEPTH = 16;
   localparam int AB    = 4;

   logic          clk = 1'b0;
   logic          rst, valid_in, out_ready;
   logic [CB-1:0] mv1, mv2, mv3, od1, od2, od3;
   logic          out_valid, overflow, frame_done;
   logic [AB:0]   count;
`ifdef POOL_OUT_LAST_EN
   logic          out_last;
`endif

   always #5 clk = ~clk;

   pool_out_fifo #(
      .CONV_BIT(CB), .HALF_WIDTH(HW), .HALF_HEIGHT(HH), .DEPTH(DEPTH), .ADDR_BIT(AB)
   ) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in),
      .max_value_1(mv1), .max_value_2(mv2), .max_value_3(mv3),
      .out_data_1(od1), .out_data_2(od2), .out_data_3(od3),
      .out_valid(out_valid), .out_ready(out_ready), .count(count),
      .overflow(overflow), .frame_done(frame_done)
`ifdef POOL_OUT_LAST_EN
      , .out_last(out_last)
`endif
   );

   typedef struct packed {
      logic          last;
      logic [CB-1:0] d3;
      logic [CB-1:0] d2;
      logic [CB-1:0] d1;
   } ent_t;

   ent_t q[$];
   int   m_col, m_row, fd_seen;
   logic m_ovf;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; valid_in = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      check("rst_count", count, 0);
      check("rst_valid", out_valid, 0);
      check("rst_ovf", overflow, 0);
      check("rst_fd", frame_done, 0);
      rst = 1'b0;
      q.delete(); m_col = 0; m_row = 0; m_ovf = 1'b0;
   endtask

   task automatic push_n(input int n);
      for (int i = 1; i <= n; i++) begin
         valid_in = 1'b1; mv1 = CB'(i); mv2 = CB'(i + 32); mv3 = CB'(i + 64);
         @(posedge clk); #1;
      end
      valid_in = 1'b0;
   endtask

   // Reference model: queue of expected entries plus frame position; checks every cycle.
   task automatic stream(input int n, input int duty, input bit rnd_ready, input bit drain);
      int            sent = 0;
      int            cyc = 0;
      bit            v, r, pop, exp_fd;
      ent_t          e, h;
      logic [CB-1:0] id;
      fd_seen = 0;
      while ((sent < n || (drain && q.size() != 0)) && cyc < 4000) begin
         v  = (sent < n) && ($urandom_range(0, 99) < duty);
         r  = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         id = CB'(sent + 1);
         valid_in = v; out_ready = r;
         mv1 = id; mv2 = id ^ 12'hA5A; mv3 = ~id;
         check("s_valid", out_valid, q.size() != 0);
`ifdef POOL_OUT_LAST_EN
         check("s_last", out_last, (q.size() != 0) ? q[0].last : 1'b0);
`endif
         pop    = r && (q.size() != 0);
         exp_fd = 1'b0;
         if (pop) begin
            h = q.pop_front();
            check("s_d1", od1, h.d1);
            check("s_d2", od2, h.d2);
            check("s_d3", od3, h.d3);
            exp_fd = h.last;
         end
         if (v) begin
            e.d1 = id; e.d2 = id ^ 12'hA5A; e.d3 = ~id;
            e.last = (m_col == HW - 1) && (m_row == HH - 1);
            if (q.size() < DEPTH) q.push_back(e);
            else m_ovf = 1'b1;
            if (m_col == HW - 1) begin
               m_col = 0;
               m_row = (m_row == HH - 1) ? 0 : m_row + 1;
            end else begin
               m_col++;
            end
            sent++;
         end
         @(posedge clk); #1;
         cyc++;
         check("s_fd", frame_done, exp_fd);
         if (frame_done) fd_seen++;
         check("s_count", count, q.size());
      end
      valid_in = 1'b0; out_ready = 1'b0;
      check("s_timeout", cyc < 4000, 1);
      check("s_ovf", overflow, m_ovf);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; valid_in = 1'b0; out_ready = 1'b0;
      mv1 = '0; mv2 = '0; mv3 = '0;
      do_reset();

      // Single sample, one-cycle latency into empty FIFO, then popped.
      valid_in = 1'b1; out_ready = 1'b1; mv1 = 12'd5; mv2 = 12'd0; mv3 = 12'd7;
      @(posedge clk); #1;
      valid_in = 1'b0;
      check("one_valid", out_valid, 1);
      check("one_d1", od1, 5);
      check("one_d2", od2, 0);
      check("one_d3", od3, 7);
      check("one_count", count, 1);
      @(posedge clk); #1;
      check("one_count0", count, 0);
      check("one_valid0", out_valid, 0);
      check("one_fd", frame_done, 0);
      out_ready = 1'b0;

      // Fill past full with the consumer stalled: 17th sample dropped.
      do_reset();
      push_n(16);
      check("full_count", count, 16);
      check("full_ovf0", overflow, 0);
      valid_in = 1'b1; mv1 = 12'd17; mv2 = 12'd49; mv3 = 12'd81;
      @(posedge clk); #1;
      valid_in = 1'b0;
      check("drop_count", count, 16);
      check("drop_ovf", overflow, 1);
      out_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         check("drain_d1", od1, i);
         check("drain_d3", od3, i + 64);
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      check("drain_count", count, 0);
      check("drain_valid", out_valid, 0);
      check("ovf_sticky", overflow, 1);

      // Full with simultaneous read and write: accepted, no overflow.
      do_reset();
      push_n(16);
      valid_in = 1'b1; out_ready = 1'b1; mv1 = 12'd99; mv2 = 12'd98; mv3 = 12'd97;
      @(posedge clk); #1;
      valid_in = 1'b0; out_ready = 1'b0;
      check("rw_count", count, 16);
      check("rw_ovf", overflow, 0);
      check("rw_head", od1, 2);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i == 15) check("rw_tail", od1, 99);
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      check("rw_count0", count, 0);

      // Full 12x12 frame at full rate.
      do_reset();
      stream(144, 100, 1'b0, 1'b1);
      check("frame_fd_once", fd_seen, 1);

      // Reset mid-frame with entries held, then a full frame realigned to col 0, row 0.
      do_reset();
      stream(50, 100, 1'b1, 1'b0);
      check("pre_rst_fd", fd_seen, 0);
      rst = 1'b1; #1;
      check("async_count", count, 0);
      check("async_valid", out_valid, 0);
      do_reset();
      stream(144, 100, 1'b0, 1'b1);
      check("post_rst_fd_once", fd_seen, 1);

      // Bursty source and stalling consumer: order preserved.
      do_reset();
      stream(144, 50, 1'b1, 1'b1);
      check("rand_fd_once", fd_seen, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
